rgb_pixel_fifo: RTL and testbench
=================================

Name: rgb_pixel_fifo

Overview:
- Synchronous first-word-fall-through FIFO that buffers 3-bit RGB pixels from the pixel source (host/UART loader) ahead of the framebuffer memory codec.
- Drives the codec's RGBin and fifoempty inputs.
- The codec pops one pixel per completed memory write. It pulses we, and we is wired to rd_en.
- Absorbs bursty writes during active display, when the codec cannot write memory.

Parameters:
- DATA_WIDTH, 3, pixel width in bits (R,G,B packed [2:0]).
- DEPTH, 16, number of entries; must be a power of two ≥ 4.
- AFULL_THR, 12, almost_full asserts when level ≥ this value; range 1..DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  push request
- wr_data  input  DATA_WIDTH  pixel to push
- rd_en  input  1  pop request (connected to codec we)
- clr_flags  input  1  clears sticky overflow/underflow flags
- rd_data  output  DATA_WIDTH  head entry (to codec RGBin); 0 when empty
- empty  output  1  no entries (to codec fifoempty)
- full  output  1  level == DEPTH
- almost_full  output  1  level ≥ AFULL_THR
- level  output  $clog2(DEPTH)+1  current entry count
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values:
  - wr_ptr = rd_ptr = 0, level = 0.
  - empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, rd_data = 0.
  - Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level is tracked as an explicit counter.
- Accepted push = wr_en & ~full. The entry is written at wr_ptr on the clock edge and wr_ptr increments.
- Accepted pop = rd_en & ~empty. rd_ptr increments on the clock edge.
- Full blocks a push even when a pop occurs in the same cycle. A push while full is dropped and sets overflow.
- A pop while empty is ignored and sets underflow. A push in that same cycle is still accepted.
- level update:
  - +1 on push only, −1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH; never below 0.
- FWFT timing:
  - rd_data = mem[rd_ptr] combinationally whenever empty = 0; forced to 0 when empty.
  - A pushed word is visible on rd_data, with empty = 0, the cycle after the push edge. Latency is 1 cycle.
- empty, full and almost_full are combinational decodes of the registered level.
- Sticky flags:
  - Cleared by reset or clr_flags.
  - If clr_flags coincides with a new error event, the flag stays set (set wins).
- Reset asserted mid-burst discards all contents. Pushes and pops in the reset cycle are ignored.
- No combinational path from wr_en to empty or rd_data. rd_en affects only registered state.

Optional Feature:
- Macro: RGB_PIXEL_FIFO_WATERMARK_EN.
- When defined:
  - Adds output max_level, width $clog2(DEPTH)+1.
  - Register holds the highest level reached since reset or the last clr_flags. Updates when level exceeds max_level.
  - On clr_flags it loads the current level.
  - Reset value 0.
- When undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Shared package fb_pkg holds:
  - RGB pixel width constant (3) and bit indices R=2, G=1, B=0.
  - Default FIFO depth and threshold constants, reused by the codec top-level.
- One natural sub-module: fifo_ram_1r1w, a DEPTH×DATA_WIDTH array with a synchronous write port and an asynchronous read port. Pointer, level and flag logic stay in rgb_pixel_fifo.

Test Plan:
- After reset, push 3'b101 once -> next cycle empty=0, rd_data=3'b101, level=1; pop -> empty=1, rd_data=0, level=0.
- Push 16 distinct values 0..15 mod 8 -> full=1, level=16, almost_full rose when level hit 12; 17th push -> overflow=1, contents unchanged; pop all 16 -> same order, empty=1.
- Fill to 16, then wr_en=rd_en=1 for 1 cycle -> push dropped, overflow=1, level=15.
- Fill to 5, then simultaneous push/pop for 40 cycles (pointers wrap twice) -> level stays 5, output order preserved.
- Empty FIFO, rd_en=1 with wr_en=1 and wr_data=3'b011 -> underflow=1, level=1, rd_data=3'b011 next cycle; clr_flags=1 -> underflow=0.
- Fill to 9, assert reset 1 cycle while wr_en=1 -> level=0, empty=1, flags 0; with WATERMARK_EN, max_level=0 after reset and 9 before it.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer constants: RGB pixel layout and default pixel FIFO sizing.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Contents:
//   PIX_W / PIX_R / PIX_G / PIX_B : pixel width and colour bit positions
//   FIFO_DEPTH / FIFO_AFULL_THR   : default pixel FIFO sizing, also used by the codec top
//   rgb_t / rgb_pack               : packed pixel view and a builder for it
package fb_pkg;

  // One pixel is three single-bit colour planes packed as {R,G,B}.
  localparam int PIX_W = 3;
  localparam int PIX_R = 2;
  localparam int PIX_G = 1;
  localparam int PIX_B = 0;

  // Default sizing of the pixel FIFO in front of the memory codec.
  localparam int FIFO_DEPTH     = 16;
  localparam int FIFO_AFULL_THR = 12;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  function automatic logic [PIX_W-1:0] rgb_pack(input logic r, input logic g, input logic b);
    logic [PIX_W-1:0] p;
    p        = '0;
    p[PIX_R] = r;
    p[PIX_G] = g;
    p[PIX_B] = b;
    return p;
  endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// DEPTH x DATA_WIDTH storage array with one synchronous write port and one asynchronous read port.
// Latency: write lands on the clock edge; read data follows raddr combinationally.
// Backpressure: none; the caller guarantees that only legal writes are issued.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data at raddr
// Contents are intentionally not reset; the owner tracks validity.
module fifo_ram_1r1w #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rgb_pixel_fifo.sv
// First-word-fall-through pixel FIFO between the pixel loader and the framebuffer memory codec.
// Latency: a pushed pixel appears on rd_data (empty low) one cycle after its push edge.
// Backpressure: full drops pushes (sets sticky overflow); pops while empty are ignored (sets underflow).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wr_en, wr_data        : push request and pixel
//   rd_en                 : pop request (codec we)
//   clr_flags             : clears sticky overflow/underflow (and reloads max_level)
//   rd_data, empty        : head pixel (0 when empty) and empty flag to the codec
//   full, almost_full     : level == DEPTH, level >= AFULL_THR
//   level                 : current entry count
//   overflow, underflow   : sticky error flags
//   max_level             : high watermark, only when RGB_PIXEL_FIFO_WATERMARK_EN is defined
// DEPTH must be a power of two >= 4 so the pointers wrap naturally; AFULL_THR in 1..DEPTH.
module rgb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AFULL_THR  = FIFO_AFULL_THR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  input  logic                       clr_flags,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
`ifdef RGB_PIXEL_FIFO_WATERMARK_EN
  output logic [$clog2(DEPTH):0]     max_level,
`endif
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL_THR);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic push;
  logic pop;
  logic ovf_evt;
  logic unf_evt;

  // Status flags are decoded from the registered count only, so neither
  // wr_en nor rd_en has a combinational path to empty/full/rd_data.
  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_FULL);
  assign almost_full = (level_q >= LVL_AFULL);
  assign level       = level_q;

  // Full blocks a push even if a pop happens in the same cycle.
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign ovf_evt = wr_en & full;
  assign unf_evt = rd_en & empty;

  fifo_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~reset),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Stale array contents are masked so the codec sees 0 when nothing is queued.
  assign rd_data = empty ? '0 : ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky errors: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr_flags) begin
      overflow_q  <= ovf_evt;
      underflow_q <= unf_evt;
    end else begin
      overflow_q  <= overflow_q  | ovf_evt;
      underflow_q <= underflow_q | unf_evt;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef RGB_PIXEL_FIFO_WATERMARK_EN
  // High watermark follows the registered level, so it trails a new peak by one cycle.
  logic [LW-1:0] max_level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      max_level_q <= '0;
    end else if (clr_flags) begin
      max_level_q <= level_q;
    end else if (level_q > max_level_q) begin
      max_level_q <= level_q;
    end
  end

  assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_rgb_pixel_fifo.sv
// Self-checking bench for rgb_pixel_fifo: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_rgb_pixel_fifo;

  localparam int DW  = 3;
  localparam int DEP = 16;
  localparam int THR = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          clr_flags;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [4:0]    level;
  logic          overflow;
  logic          underflow;
`ifdef RGB_PIXEL_FIFO_WATERMARK_EN
  logic [4:0]    max_level;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model
  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_unf;
  int            m_max;

  always #5 clk = ~clk;

  rgb_pixel_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .AFULL_THR(THR)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .clr_flags   (clr_flags),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
`ifdef RGB_PIXEL_FIFO_WATERMARK_EN
    .max_level   (max_level),
`endif
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level",       32'(level),       32'(n));
    chk("empty",       32'(empty),       32'(n == 0));
    chk("full",        32'(full),        32'(n == DEP));
    chk("almost_full", 32'(almost_full), 32'(n >= THR));
    chk("rd_data",     32'(rd_data),     (n > 0) ? 32'(q[0]) : 32'd0);
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("underflow",   32'(underflow),   32'(m_unf));
`ifdef RGB_PIXEL_FIFO_WATERMARK_EN
    chk("max_level",   32'(max_level),   32'(m_max));
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd, input logic clr);
    int  n;
    bit  do_push, do_pop, e_ovf, e_unf;
    reset = r; wr_en = w; wr_data = d; rd_en = rd; clr_flags = clr;
    n = q.size();
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_max = 0;
    end else begin
      do_push = w && (n < DEP);
      do_pop  = rd && (n > 0);
      e_ovf   = w && (n == DEP);
      e_unf   = rd && (n == 0);
      if (clr)          m_max = n;
      else if (n > m_max) m_max = n;
      m_ovf = clr ? e_ovf : (m_ovf | e_ovf);
      m_unf = clr ? e_unf : (m_unf | e_unf);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEP + 2 && q.size() > 0; i++) pop();
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_flags = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_max = 0;

    // Reset state
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Single push / pop with one-cycle fall-through
    push(3'b101);
    chk("single_rd_data", 32'(rd_data), 32'd5);
    chk("single_level", 32'(level), 32'd1);
    pop();
    chk("single_empty", 32'(empty), 32'd1);

    // Fill with 0..15 mod 8, overflow on the 17th, drain in order
    for (int i = 0; i < DEP; i++) push(3'(i % 8));
    chk("fill_full", 32'(full), 32'd1);
    push(3'd6);
    chk("fill_ovf", 32'(overflow), 32'd1);
    drain();

    // Full with simultaneous push/pop: push dropped, one pop taken
    for (int i = 0; i < DEP; i++) push(3'($urandom));
    step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    chk("fullrw_level", 32'(level), 32'd15);
    chk("fullrw_ovf", 32'(overflow), 32'd1);
    drain();

    // Steady-state streaming at level 5, pointers wrap
    for (int i = 0; i < 5; i++) push(3'($urandom));
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 3'($urandom), 1'b1, 1'b0);
    chk("stream_level", 32'(level), 32'd5);
    drain();

    // Pop while empty with concurrent push
    step(1'b0, 1'b1, 3'b011, 1'b1, 1'b0);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_rd_data", 32'(rd_data), 32'd3);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("unf_clr", 32'(underflow), 32'd0);
    // Clear coinciding with a new error keeps the flag set
    pop();
    step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    chk("unf_set_wins", 32'(underflow), 32'd1);
    drain();

    // Reset mid-burst discards contents
    for (int i = 0; i < 9; i++) push(3'($urandom));
    idle();
`ifdef RGB_PIXEL_FIFO_WATERMARK_EN
    chk("wm_before_rst", 32'(max_level), 32'd9);
`endif
    step(1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    idle();

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 800; i++) begin
      int  ph;
      logic w, rd, clr, r;
      ph  = (i / 100) % 2;
      w   = (ph == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      rd  = (ph == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 31) == 0);
      r   = ($urandom_range(0, 199) == 0);
      step(r, w, 3'($urandom), rd, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
